// File: rtl/util_adc_timestamp_insert.sv
// Inserts a 64-bit sample-index header word every timestamp_every samples into an
// ADC stream, buffering samples in a small skid FIFO while headers take output slots.
module util_adc_timestamp_insert #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           timestamp_every,
    input  logic                  adc_valid_in,
    input  logic [DATA_WIDTH-1:0] adc_data_in,
    output logic                  adc_valid_out,
    output logic [DATA_WIDTH-1:0] adc_data_out,
    output logic                  timestamp_wr_sync,
    output logic                  overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic {S_IDLE, S_DATA} state_t;

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [63:0]           idx_mem  [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic [63:0]           sample_idx_q;
    logic [31:0]           remaining_q, remaining_d;
    state_t                state_q, state_d;
    logic                  overflow_q;

    logic                  valid_q, valid_d;
    logic                  sync_q, sync_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  fifo_empty, fifo_full;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic [63:0]           head_idx;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push       = adc_valid_in && (!fifo_full || pop);
    assign head_data  = data_mem[rd_ptr_q];
    assign head_idx   = idx_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= adc_data_in;
            idx_mem[wr_ptr_q]  <= sample_idx_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sample_idx_q <= '0;
            overflow_q   <= 1'b0;
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            valid_q      <= 1'b0;
            sync_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (adc_valid_in) begin
                sample_idx_q <= sample_idx_q + 64'd1;
            end
            if (adc_valid_in && !push) begin
                overflow_q <= 1'b1;
            end
            state_q     <= state_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            sync_q      <= sync_d;
            data_q      <= data_d;
        end
    end

    // The header is emitted on the block-boundary decision cycle itself, so a new
    // block costs exactly one output slot and timestamp_every is sampled only here.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && (timestamp_every != 32'd0)) begin
                    remaining_d = timestamp_every;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (!fifo_empty) begin
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        sync_d  = 1'b0;
        data_d  = '0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    valid_d = 1'b1;
                    if (timestamp_every == 32'd0) begin
                        pop    = 1'b1;
                        data_d = head_data;
                    end else begin
                        sync_d       = 1'b1;
                        data_d[63:0] = head_idx;
                    end
                end
            end
            S_DATA: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    data_d  = head_data;
                end
            end
            default: ;
        endcase
    end

    assign adc_valid_out     = valid_q;
    assign adc_data_out      = data_q;
    assign timestamp_wr_sync = sync_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_util_adc_timestamp_insert.sv
// Directed and randomized checks of util_adc_timestamp_insert against a queue-based
// model of the timestamp insertion rules.
module tb_util_adc_timestamp_insert;

    localparam int DW    = 96;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   timestamp_every = '0;
    logic          adc_valid_in = 1'b0;
    logic [DW-1:0] adc_data_in = '0;
    logic          adc_valid_out;
    logic [DW-1:0] adc_data_out;
    logic          timestamp_wr_sync;
    logic          overflow;

    util_adc_timestamp_insert #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .timestamp_every   (timestamp_every),
        .adc_valid_in      (adc_valid_in),
        .adc_data_in       (adc_data_in),
        .adc_valid_out     (adc_valid_out),
        .adc_data_out      (adc_data_out),
        .timestamp_wr_sync (timestamp_wr_sync),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [63:0]   i;
    } ent_t;

    ent_t          mq[$];
    logic [63:0]   m_idx;
    longint        blk_left;
    logic          exp_v, exp_s, exp_ovf;
    logic [DW-1:0] exp_d;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_idx    = '0;
        blk_left = 0;
        exp_ovf  = 1'b0;
    endtask

    // One clock edge of the reference: pick the output word, then take the input.
    task automatic model_edge(input logic v, input logic [DW-1:0] d);
        exp_v = 1'b0;
        exp_s = 1'b0;
        exp_d = '0;
        if (mq.size() > 0) begin
            exp_v = 1'b1;
            if (blk_left == 0 && timestamp_every != 0) begin
                exp_s       = 1'b1;
                exp_d[63:0] = mq[0].i;
                blk_left    = longint'(timestamp_every);
            end else begin
                exp_d = mq[0].d;
                void'(mq.pop_front());
                if (blk_left > 0) blk_left--;
            end
        end
        if (v) begin
            if (mq.size() < DEPTH) mq.push_back('{d: d, i: m_idx});
            else exp_ovf = 1'b1;
            m_idx = m_idx + 64'd1;
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d);
        adc_valid_in = v;
        adc_data_in  = d;
        model_edge(v, d);
        @(posedge clk);
        #1;
        cyc++;
        chk("valid", DW'(adc_valid_out), DW'(exp_v));
        chk("sync", DW'(timestamp_wr_sync), DW'(exp_s));
        chk("overflow", DW'(overflow), DW'(exp_ovf));
        if (exp_v) chk("data", adc_data_out, exp_d);
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0);
    endtask

    task automatic spaced(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            step(1'b1, rnd());
            idle(gap - 1);
        end
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_valid", DW'(adc_valid_out), '0);
        chk("rst_sync", DW'(timestamp_wr_sync), '0);
        chk("rst_data", adc_data_out, '0);
        chk("rst_ovf", DW'(overflow), '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("init_valid", DW'(adc_valid_out), '0);
        chk("init_sync", DW'(timestamp_wr_sync), '0);
        chk("init_data", adc_data_out, '0);
        chk("init_ovf", DW'(overflow), '0);
        reset = 1'b0;
        @(negedge clk);

        // passthrough, samples every other cycle
        timestamp_every = 32'd0;
        spaced(10, 2);
        idle(3);

        // headers every 4 samples, sparse input
        timestamp_every = 32'd4;
        spaced(12, 3);
        idle(4);

        // headers every 4 samples, back-to-back input absorbed by the FIFO
        for (int k = 0; k < 12; k++) step(1'b1, rnd());
        idle(8);
        chk("b2b_no_ovf", DW'(overflow), '0);

        // disable mid-block, then re-enable
        timestamp_every = 32'd4;
        spaced(2, 3);
        timestamp_every = 32'd0;
        spaced(5, 3);
        timestamp_every = 32'd2;
        spaced(5, 3);
        idle(4);

        // every=1 at full rate must overflow and stay sticky
        timestamp_every = 32'd1;
        for (int k = 0; k < 16; k++) step(1'b1, rnd());
        idle(12);
        chk("ovf_sticky", DW'(overflow), 1'b1);

        // reset mid-block with three entries buffered
        do_reset();
        timestamp_every = 32'd4;
        for (int k = 0; k < 40 && mq.size() != 3; k++) step(1'b1, rnd());
        chk("fifo_fill3", DW'(mq.size()), DW'(3));
        do_reset();
        step(1'b1, rnd());
        step(1'b0, '0);
        chk("hdr_after_rst_sync", DW'(timestamp_wr_sync), 1'b1);
        chk("hdr_after_rst_idx", adc_data_out, '0);
        idle(6);

        // randomized traffic with changing block sizes
        for (int ph = 0; ph < 6; ph++) begin
            timestamp_every = 32'($urandom_range(0, 5));
            for (int k = 0; k < 40; k++) step(($urandom_range(0, 99) < 40), rnd());
        end
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
